axi_master_burst: RTL and testbench

- Single-outstanding AXI4 burst initiator that converts simple command, write-stream and read-stream interfaces into AXI4 INCR bursts.
- Sits on the master side of the link facing axi_slave_skid.
- Used by test engines and DMA-style clients to move bursts of up to 256 beats to and from the slave memory.
- Only one transaction (read or write) is in flight at a time.

---
 rtl/axi_master_burst.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_master_burst.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_burst.sv
// Single-outstanding AXI4 INCR burst initiator: one command in, one AW/W/B or
// AR/R exchange out, finished by a one-cycle done pulse carrying the response.
module axi_master_burst #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 1,
  parameter int TXN_ID     = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic [ID_WIDTH-1:0]   M_AWID,
  output logic [ADDR_WIDTH-1:0] M_AWADDR,
  output logic [7:0]            M_AWLEN,
  output logic [2:0]            M_AWSIZE,
  output logic [1:0]            M_AWBURST,
  output logic                  M_AWLOCK,
  output logic [3:0]            M_AWCACHE,
  output logic [2:0]            M_AWPROT,
  output logic [3:0]            M_AWQOS,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  output logic [DATA_WIDTH-1:0] M_WDATA,
  output logic [STRB_WIDTH-1:0] M_WSTRB,
  output logic                  M_WLAST,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  input  logic [ID_WIDTH-1:0]   M_BID,
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  output logic [ID_WIDTH-1:0]   M_ARID,
  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic [7:0]            M_ARLEN,
  output logic [2:0]            M_ARSIZE,
  output logic [1:0]            M_ARBURST,
  output logic                  M_ARLOCK,
  output logic [3:0]            M_ARCACHE,
  output logic [2:0]            M_ARPROT,
  output logic [3:0]            M_ARQOS,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [ID_WIDTH-1:0]   M_RID,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RLAST,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  localparam int unsigned SIZE_LOG = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << SIZE_LOG) - ADDR_WIDTH'(1));
  localparam logic [ID_WIDTH-1:0] ID_C = ID_WIDTH'(TXN_ID);

  typedef enum logic [2:0] {
    IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [8:0]              beat_q;
  logic [8:0]              beat_d;
  logic                    awvalid_q;
  logic                    arvalid_q;
  logic                    bready_q;
  logic                    done_q;
  logic [1:0]              done_resp_q;
  logic                    err_q;
  logic                    err_d;
  logic                    in_w;
  logic                    in_r;
  logic                    at_last;
  logic                    w_fire;
  logic                    r_fire;
  logic                    r_err;

  assign in_w    = (state_q == WDATA);
  assign in_r    = (state_q == RDATA);
  assign at_last = (beat_q == {1'b0, len_q});
  assign beat_d  = beat_q + 9'd1;

  assign cmd_ready = (state_q == IDLE);

  assign M_WVALID = in_w & wr_valid;
  assign wr_ready = in_w & M_WREADY;
  assign M_WDATA  = wr_data;
  assign M_WSTRB  = wr_strb;
  assign M_WLAST  = in_w & at_last;
  assign w_fire   = M_WVALID & M_WREADY;

  assign rd_valid = in_r & M_RVALID;
  assign M_RREADY = in_r & rd_ready;
  assign rd_data  = M_RDATA;
  assign rd_last  = in_r & at_last;
  assign r_fire   = rd_valid & rd_ready;

  // EXOKAY folds to OKAY; an early RLAST or foreign RID is a protocol error.
  assign r_err = (M_RRESP >= 2'b10) | (M_RLAST & ~at_last) | (M_RID != ID_C);
  assign err_d = err_q | r_err;

  assign M_AWID    = ID_C;
  assign M_AWADDR  = addr_q;
  assign M_AWLEN   = len_q;
  assign M_AWSIZE  = 3'(SIZE_LOG);
  assign M_AWBURST = 2'b01;
  assign M_AWLOCK  = 1'b0;
  assign M_AWCACHE = '0;
  assign M_AWPROT  = '0;
  assign M_AWQOS   = '0;
  assign M_AWVALID = awvalid_q;

  assign M_ARID    = ID_C;
  assign M_ARADDR  = addr_q;
  assign M_ARLEN   = len_q;
  assign M_ARSIZE  = 3'(SIZE_LOG);
  assign M_ARBURST = 2'b01;
  assign M_ARLOCK  = 1'b0;
  assign M_ARCACHE = '0;
  assign M_ARPROT  = '0;
  assign M_ARQOS   = '0;
  assign M_ARVALID = arvalid_q;

  assign M_BREADY  = bready_q;
  assign done      = done_q;
  assign done_resp = done_resp_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      done_resp_q <= '0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr & ADDR_MASK;
            len_q  <= cmd_len;
            err_q  <= 1'b0;
            if (cmd_we) begin
              awvalid_q <= 1'b1;
              state_q   <= WADDR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RADDR;
            end
          end
        end
        WADDR: begin
          if (M_AWREADY) begin
            awvalid_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= WDATA;
          end
        end
        WDATA: begin
          if (w_fire) begin
            beat_q <= beat_d;
            if (at_last) begin
              bready_q <= 1'b1;
              state_q  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (M_BVALID) begin
            bready_q    <= 1'b0;
            done_q      <= 1'b1;
            done_resp_q <= (M_BID != ID_C) ? 2'b10 : M_BRESP;
            state_q     <= DONE;
          end
        end
        RADDR: begin
          if (M_ARREADY) begin
            arvalid_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= RDATA;
          end
        end
        RDATA: begin
          if (r_fire) begin
            beat_q <= beat_d;
            err_q  <= err_d;
            if (at_last) begin
              done_q      <= 1'b1;
              done_resp_q <= {err_d, 1'b0};
              state_q     <= DONE;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_burst.sv
// Bench for axi_master_burst: bench-side AXI slave and stream client, with
// expectations derived from the planned beats and responses of each transaction.
module tb_axi_master_burst;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic          id;
  } ax_t;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last, rd_valid, rd_ready;
  logic          done;
  logic [1:0]    done_resp;
  logic [0:0]    M_AWID, M_ARID, M_BID, M_RID;
  logic [AW-1:0] M_AWADDR, M_ARADDR;
  logic [7:0]    M_AWLEN, M_ARLEN;
  logic [2:0]    M_AWSIZE, M_ARSIZE, M_AWPROT, M_ARPROT;
  logic [1:0]    M_AWBURST, M_ARBURST, M_BRESP, M_RRESP;
  logic          M_AWLOCK, M_ARLOCK;
  logic [3:0]    M_AWCACHE, M_ARCACHE, M_AWQOS, M_ARQOS;
  logic          M_AWVALID, M_AWREADY, M_ARVALID, M_ARREADY;
  logic [DW-1:0] M_WDATA, M_RDATA;
  logic [SW-1:0] M_WSTRB;
  logic          M_WLAST, M_WVALID, M_WREADY;
  logic          M_BVALID, M_BREADY;
  logic          M_RLAST, M_RVALID, M_RREADY;

  always #5 ACLK = ~ACLK;

  axi_master_burst #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .ID_WIDTH(1), .TXN_ID(0)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp),
    .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
    .M_AWBURST(M_AWBURST), .M_AWLOCK(M_AWLOCK), .M_AWCACHE(M_AWCACHE),
    .M_AWPROT(M_AWPROT), .M_AWQOS(M_AWQOS), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
    .M_WREADY(M_WREADY),
    .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
    .M_ARBURST(M_ARBURST), .M_ARLOCK(M_ARLOCK), .M_ARCACHE(M_ARCACHE),
    .M_ARPROT(M_ARPROT), .M_ARQOS(M_ARQOS), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Per-transaction plan: client write beats and slave read beats.
  logic [DW-1:0] wq_data[$];
  logic [SW-1:0] wq_strb[$];
  logic [DW-1:0] r_data[$];
  logic [1:0]    r_resp[$];
  logic          r_last[$];
  logic          r_id[$];
  int            wptr, r_idx;
  bit            ar_seen, b_pend, cmd_pend;
  logic [1:0]    b_resp_cfg;
  logic          b_id_cfg;
  int            wr_mode, rd_mode;
  bit            ax_rand, v_rand;

  ax_t             aw_q[$], ar_q[$];
  logic [DW+SW:0]  wobs[$];
  logic [DW:0]     robs[$];
  int              done_cnt, done_cyc, accept_cyc;
  logic [1:0]      done_resp_obs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return logic'(cyc % 2 == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic step();
    @(negedge ACLK);
    cyc++;
    cmd_valid = cmd_pend;
    M_AWREADY = ax_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    M_ARREADY = ax_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    M_WREADY  = pick(wr_mode);
    if (wptr < wq_data.size()) begin
      wr_valid = v_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data  = wq_data[wptr];
      wr_strb  = wq_strb[wptr];
    end else begin
      wr_valid = 1'b0;
      wr_data  = '0;
      wr_strb  = '0;
    end
    M_BVALID = b_pend && (v_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    M_BRESP  = b_resp_cfg;
    M_BID    = b_id_cfg;
    if (ar_seen && r_idx < r_data.size()) begin
      M_RVALID = v_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      M_RDATA  = r_data[r_idx];
      M_RRESP  = r_resp[r_idx];
      M_RLAST  = r_last[r_idx];
      M_RID    = r_id[r_idx];
    end else begin
      M_RVALID = 1'b0;
      M_RDATA  = '0;
      M_RRESP  = '0;
      M_RLAST  = 1'b0;
      M_RID    = '0;
    end
    rd_ready = pick(rd_mode);
    #1;
    if (cmd_valid && cmd_ready) begin
      accept_cyc = cyc;
      cmd_pend   = 1'b0;
    end
    if (M_AWVALID && M_AWREADY)
      aw_q.push_back('{M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWID});
    if (M_ARVALID && M_ARREADY) begin
      ar_q.push_back('{M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARID});
      ar_seen = 1'b1;
    end
    if (M_WVALID && M_WREADY) begin
      wobs.push_back({M_WDATA, M_WSTRB, M_WLAST});
      if (M_WLAST) b_pend = 1'b1;
    end
    if (wr_valid && wr_ready) wptr++;
    if (M_BVALID && M_BREADY) b_pend = 1'b0;
    if (rd_valid && rd_ready) robs.push_back({rd_data, rd_last});
    if (M_RVALID && M_RREADY) r_idx++;
    if (done) begin
      done_cnt++;
      done_cyc      = cyc;
      done_resp_obs = done_resp;
    end
  endtask

  task automatic clear_txn();
    wq_data.delete(); wq_strb.delete();
    r_data.delete(); r_resp.delete(); r_last.delete(); r_id.delete();
    aw_q.delete(); ar_q.delete(); wobs.delete(); robs.delete();
    wptr = 0; r_idx = 0; ar_seen = 0; b_pend = 0; cmd_pend = 0;
    done_cnt = 0; done_cyc = -1; accept_cyc = -1; done_resp_obs = '0;
  endtask

  task automatic plan_write(input int len);
    clear_txn();
    for (int i = 0; i <= len; i++) begin
      wq_data.push_back($urandom);
      wq_strb.push_back(4'($urandom));
    end
  endtask

  task automatic plan_read(input int len);
    clear_txn();
    for (int i = 0; i <= len; i++) begin
      r_data.push_back($urandom);
      r_resp.push_back(2'b00);
      r_last.push_back(logic'(i == len));
      r_id.push_back(1'b0);
    end
  endtask

  // Issue the planned command and compare everything observed against the plan.
  task automatic run(input bit we, input logic [AW-1:0] addr, input int len, input bit chk_lat);
    ax_t        e;
    logic [1:0] exp_resp;
    bit         err;
    cmd_we   = we;
    cmd_addr = addr;
    cmd_len  = 8'(len);
    cmd_pend = 1'b1;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
    check("done_seen", 64'(done_cnt), 64'd1);
    step();
    check("done_width", 64'(done), 64'd0);
    check("ready_after_done", 64'(cmd_ready), 64'd1);
    e = '{addr & ~10'h3, 8'(len), 3'd2, 2'b01, 1'b0};
    if (we) begin
      check("aw_count", 64'(aw_q.size()), 64'd1);
      check("ar_count", 64'(ar_q.size()), 64'd0);
      if (aw_q.size() > 0) check("aw_fields", 64'(aw_q[0]), 64'(e));
      check("w_count", 64'(wobs.size()), 64'(len + 1));
      for (int i = 0; i < wobs.size() && i <= len; i++)
        check("w_beat", 64'(wobs[i]), 64'({wq_data[i], wq_strb[i], logic'(i == len)}));
      exp_resp = (b_resp_cfg[1] || b_id_cfg != 1'b0) ? 2'b10 : 2'b00;
    end else begin
      check("ar_count", 64'(ar_q.size()), 64'd1);
      check("aw_count", 64'(aw_q.size()), 64'd0);
      if (ar_q.size() > 0) check("ar_fields", 64'(ar_q[0]), 64'(e));
      check("r_count", 64'(robs.size()), 64'(len + 1));
      check("r_consumed", 64'(r_idx), 64'(len + 1));
      for (int i = 0; i < robs.size() && i <= len; i++)
        check("r_beat", 64'(robs[i]), 64'({r_data[i], logic'(i == len)}));
      err = 0;
      for (int i = 0; i <= len; i++)
        if (r_resp[i][1] || r_id[i] != 1'b0 || (r_last[i] && i != len)) err = 1;
      exp_resp = err ? 2'b10 : 2'b00;
    end
    check("done_resp", 64'(done_resp_obs), 64'(exp_resp));
    if (chk_lat) check("latency", 64'(done_cyc - accept_cyc), 64'd4);
  endtask

  initial begin
    ARESETn = 1'b0;
    cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0;
    wr_mode = 0; rd_mode = 0; ax_rand = 0; v_rand = 0;
    b_resp_cfg = 2'b00; b_id_cfg = 1'b0;
    clear_txn();
    repeat (3) step();
    check("rst_awvalid", 64'(M_AWVALID), 64'd0);
    check("rst_arvalid", 64'(M_ARVALID), 64'd0);
    check("rst_bready", 64'(M_BREADY), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_done_resp", 64'(done_resp), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_wvalid", 64'(M_WVALID), 64'd0);
    check("rst_rready", 64'(M_RREADY), 64'd0);
    ARESETn = 1'b1;
    step();

    // single-beat write, zero wait states
    plan_write(0);
    wq_data[0] = 32'hDEADBEEF;
    wq_strb[0] = 4'hF;
    run(1'b1, 10'h010, 0, 1'b1);

    // 4-beat write with WREADY low every other cycle
    wr_mode = 1;
    plan_write(3);
    run(1'b1, 10'h040, 3, 1'b0);
    wr_mode = 0;

    // 8-beat read with rd_ready toggling
    rd_mode = 1;
    plan_read(7);
    run(1'b0, 10'h100, 7, 1'b0);
    rd_mode = 0;

    // SLVERR write, then a normal read
    b_resp_cfg = 2'b10;
    plan_write(1);
    run(1'b1, 10'h080, 1, 1'b0);
    b_resp_cfg = 2'b00;
    plan_read(1);
    run(1'b0, 10'h0C0, 1, 1'b0);

    // early RLAST on beat 2 of 4
    plan_read(3);
    r_last[1] = 1'b1;
    run(1'b0, 10'h200, 3, 1'b0);

    // foreign BID, foreign RID, RRESP error, EXOKAY treated as OKAY
    b_id_cfg = 1'b1;
    plan_write(0);
    run(1'b1, 10'h004, 0, 1'b0);
    b_id_cfg = 1'b0;
    plan_read(2);
    r_id[2] = 1'b1;
    run(1'b0, 10'h024, 2, 1'b0);
    plan_read(2);
    r_resp[1] = 2'b10;
    run(1'b0, 10'h034, 2, 1'b0);
    plan_read(1);
    r_resp[0] = 2'b01;
    run(1'b0, 10'h044, 1, 1'b0);

    // 256-beat bursts with random back-pressure
    ax_rand = 1; v_rand = 1; wr_mode = 2; rd_mode = 2;
    plan_write(255);
    run(1'b1, 10'h300, 255, 1'b0);
    plan_read(255);
    run(1'b0, 10'h000, 255, 1'b0);

    // random mix, unaligned start addresses
    for (int t = 0; t < 12; t++) begin
      int            len;
      logic [AW-1:0] a;
      len = int'($urandom_range(0, 20));
      a   = AW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        plan_write(len);
        run(1'b1, a, len, 1'b0);
      end else begin
        plan_read(len);
        if ($urandom_range(0, 3) == 0) r_resp[$urandom_range(0, len)] = 2'b10;
        run(1'b0, a, len, 1'b0);
      end
    end

    // reset pulse in the middle of a 16-beat write
    ax_rand = 0; v_rand = 0; wr_mode = 0; rd_mode = 0;
    plan_write(15);
    cmd_we = 1'b1; cmd_addr = 10'h180; cmd_len = 8'd15; cmd_pend = 1'b1;
    for (int i = 0; i < 200 && wobs.size() < 5; i++) step();
    check("pre_reset_beats", 64'(wobs.size() >= 5), 64'd1);
    ARESETn = 1'b0;
    step();
    check("mid_rst_awvalid", 64'(M_AWVALID), 64'd0);
    check("mid_rst_wvalid", 64'(M_WVALID), 64'd0);
    check("mid_rst_bready", 64'(M_BREADY), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_done", 64'(done), 64'd0);
    ARESETn = 1'b1;
    clear_txn();
    step();

    // recovery transaction after reset
    plan_write(2);
    run(1'b1, 10'h1F0, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
